// File: rtl/cordic_cmd_sequencer.sv
// Command front-end for the iterative CORDIC core: two-deep command and response
// buffers around the core's start/done handshake, with a per-operation watchdog.
//
// state  | meaning
// IDLE   | waiting for a queued command and a free (or freeing) response slot
// START  | one-cycle start pulse; operands already held on core_*
// WAIT   | core running; watchdog counting down to its terminal count
module cordic_cmd_sequencer #(
  parameter int FIXED_WIDTH = 16,
  parameter int SHIFT_W     = 4,
  parameter int TIMEOUT     = 31
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [FIXED_WIDTH-1:0] i_cmd_a,
  input  logic [FIXED_WIDTH-1:0] i_cmd_b,
  input  logic [1:0]             i_cmd_mode,
  input  logic                   i_cmd_rot,
  input  logic [SHIFT_W-1:0]     i_cmd_shift,
  output logic                   o_core_start,
  output logic [FIXED_WIDTH-1:0] o_core_a,
  output logic [FIXED_WIDTH-1:0] o_core_b,
  output logic [1:0]             o_core_mode,
  output logic                   o_core_rot,
  output logic [SHIFT_W-1:0]     o_core_shift,
  input  logic [FIXED_WIDTH-1:0] i_core_out1,
  input  logic [FIXED_WIDTH-1:0] i_core_out2,
  input  logic                   i_core_done,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [FIXED_WIDTH-1:0] o_rsp_out1,
  output logic [FIXED_WIDTH-1:0] o_rsp_out2,
  output logic [1:0]             o_rsp_mode,
  output logic                   o_busy,
  output logic                   o_err_timeout,
  input  logic                   i_err_clear
);

  localparam int CMD_W = 2*FIXED_WIDTH + 3 + SHIFT_W;
  localparam int RSP_W = 2*FIXED_WIDTH + 2;
  localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_start;
  logic   w_timeout;
  logic   w_cmd_push;
  logic   w_cmd_pop;
  logic   w_rsp_push;
  logic   w_rsp_pop;

  logic [CMD_W-1:0] r_cmd_mem [2];
  logic             r_cmd_wp;
  logic             r_cmd_rp;
  logic [1:0]       r_cmd_cnt;
  logic [CMD_W-1:0] w_cmd_head;

  logic [RSP_W-1:0] r_rsp_mem [2];
  logic             r_rsp_wp;
  logic             r_rsp_rp;
  logic [1:0]       r_rsp_cnt;

  logic [7:0]             r_wdog;
  logic                   r_err;
  logic [FIXED_WIDTH-1:0] r_core_a;
  logic [FIXED_WIDTH-1:0] r_core_b;
  logic [1:0]             r_core_mode;
  logic                   r_core_rot;
  logic [SHIFT_W-1:0]     r_core_shift;

  assign o_cmd_ready = (r_cmd_cnt != 2'd2);
  assign w_cmd_push  = i_cmd_valid & o_cmd_ready;
  assign w_cmd_head  = r_cmd_mem[r_cmd_rp];

  always_ff @(posedge i_clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {i_cmd_a, i_cmd_b, i_cmd_mode, i_cmd_rot, i_cmd_shift};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cmd_wp  <= 1'b0;
      r_cmd_rp  <= 1'b0;
      r_cmd_cnt <= 2'd0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= ~r_cmd_wp;
      if (w_cmd_pop)  r_cmd_rp <= ~r_cmd_rp;
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + 2'd1;
        2'b01:   r_cmd_cnt <= r_cmd_cnt - 2'd1;
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase
    end
  end

  assign o_rsp_valid = (r_rsp_cnt != 2'd0);
  assign w_rsp_pop   = o_rsp_valid & i_rsp_ready;
  assign {o_rsp_out1, o_rsp_out2, o_rsp_mode} = r_rsp_mem[r_rsp_rp];

  // Tagged with the held core_mode, which is what the core's output mux used.
  always_ff @(posedge i_clk) begin
    if (w_rsp_push) r_rsp_mem[r_rsp_wp] <= {i_core_out1, i_core_out2, r_core_mode};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rsp_wp  <= 1'b0;
      r_rsp_rp  <= 1'b0;
      r_rsp_cnt <= 2'd0;
    end else begin
      if (w_rsp_push) r_rsp_wp <= ~r_rsp_wp;
      if (w_rsp_pop)  r_rsp_rp <= ~r_rsp_rp;
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_cnt <= r_rsp_cnt + 2'd1;
        2'b01:   r_rsp_cnt <= r_rsp_cnt - 2'd1;
        default: r_rsp_cnt <= r_rsp_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // The response slot is reserved here, so the push on done never overflows.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_timeout   = 1'b0;
    w_cmd_pop   = 1'b0;
    w_rsp_push  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_cmd_cnt != 2'd0) && ((r_rsp_cnt != 2'd2) || w_rsp_pop)) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_done) begin
          w_rsp_push  = 1'b1;
          w_cmd_pop   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == 8'd1) begin
          w_timeout   = 1'b1;
          w_cmd_pop   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_core_mode  <= '0;
      r_core_rot   <= 1'b0;
      r_core_shift <= '0;
    end else if (w_load) begin
      {r_core_a, r_core_b, r_core_mode, r_core_rot, r_core_shift} <= w_cmd_head;
    end
  end

  // Loaded in START so the first WAIT cycle sees TIMEOUT; terminal count is 1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                 r_wdog <= 8'd0;
    else if (r_state == S_START)  r_wdog <= WDOG_LOAD;
    else if (r_state == S_WAIT)   r_wdog <= r_wdog - 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)         r_err <= 1'b0;
    else if (w_timeout)   r_err <= 1'b1;
    else if (i_err_clear) r_err <= 1'b0;
  end

  assign o_core_start  = w_start;
  assign o_core_a      = r_core_a;
  assign o_core_b      = r_core_b;
  assign o_core_mode   = r_core_mode;
  assign o_core_rot    = r_core_rot;
  assign o_core_shift  = r_core_shift;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err_timeout = r_err;

endmodule
